// File: rtl/vram_arbiter_pkg.sv
// Shared constants and state encoding for the video RAM arbiter.
package vram_arbiter_pkg;

  localparam int AW    = 12;   // RAM address width
  localparam int DW    = 8;    // one character code per cell
  localparam int DEPTH = 2400; // 80x30 text cells

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous video RAM with a registered read port.
// Accesses outside 0..DEPTH-1 are ignored, so the array is never indexed out of range.
module vram_sp #(
  parameter int AW    = 12,
  parameter int DW    = 8,
  parameter int DEPTH = 2400
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dout_q;

  // One access per cycle: either write the cell or register its contents.
  always_ff @(posedge clk) begin
    if (addr <= LAST_ADDR) begin
      if (we) begin
        mem_q[addr] <= din;
      end else begin
        dout_q <= mem_q[addr];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/wfifo.sv
// Host write FIFO holding {addr, data}. FD must be a power of two (>= 2).
// The caller never pushes when full nor pops when empty.
module wfifo #(
  parameter int W  = 20,
  parameter int FD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic [$clog2(FD):0] count,
  output logic               empty
);

  localparam int PW = $clog2(FD);

  logic [W-1:0]  mem_q [FD];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; stored entries are dropped by resetting these.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display reads take every slot they ask for; buffered host
// writes and the clear-screen fill use whatever slots are left, in that order.
//
// Host handshake: a write transfers on a rising pclk edge where wr_valid and
// wr_ready are both high; wr_valid may be held while wr_ready is low, and
// wr_addr/wr_data must be stable whenever wr_valid is high.
module vram_arbiter #(
  parameter int AW    = vram_arbiter_pkg::AW,
  parameter int DW    = vram_arbiter_pkg::DW,
  parameter int DEPTH = vram_arbiter_pkg::DEPTH,
  parameter int FD    = 4
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          disp_rd,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_dv,
  output logic [DW-1:0] disp_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_data,
  output logic          clr_busy,
  output logic          clr_done
);

  import vram_arbiter_pkg::*;

  localparam int            CW        = $clog2(FD) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic [DW-1:0] fill_q, fill_d;
  logic          done_q, done_d;
  logic          dv_q, dv_d;
  logic          oob_q, oob_d;

  logic             fifo_push, fifo_pop, fifo_empty;
  logic [AW+DW-1:0] fifo_head;
  logic [CW-1:0]    fifo_count;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  logic          clr_wr;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  assign head_addr = fifo_head[AW+DW-1:DW];
  assign head_data = fifo_head[DW-1:0];

  // Host writes are only taken while no clear is pending or running.
  assign wr_ready  = (fifo_count < CW'(FD)) && (state_q == ST_IDLE);
  assign fifo_push = wr_valid && wr_ready;

  // Slot mux: display read, else FIFO head, else clear fill. Nothing reaches the
  // RAM in a reset cycle so an aborted clear leaves the current cell untouched.
  always_comb begin
    fifo_pop = !reset && !disp_rd && !fifo_empty;
    clr_wr   = !reset && !disp_rd && fifo_empty && (state_q == ST_CLEAR);
    ram_we   = (fifo_pop && (head_addr <= LAST_ADDR)) || clr_wr;
    ram_addr = disp_addr;
    ram_din  = head_data;
    if (disp_rd) begin
      ram_addr = disp_addr;
    end else if (fifo_pop) begin
      ram_addr = head_addr;
    end else if (clr_wr) begin
      ram_addr = clr_ptr_q;
      ram_din  = fill_q;
    end
  end

  // Clear sequencer next state plus read-return tracking.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    fill_d    = fill_q;
    done_d    = 1'b0;
    dv_d      = disp_rd;
    oob_d     = disp_addr > LAST_ADDR;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_DRAIN;
          fill_d  = clr_data;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_wr) begin
          if (clr_ptr_q == LAST_ADDR) begin
            state_d   = ST_IDLE;
            clr_ptr_d = '0;
            done_d    = 1'b1;
          end else begin
            clr_ptr_d = clr_ptr_q + AW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_ptr_q <= '0;
      fill_q    <= '0;
      done_q    <= 1'b0;
      dv_q      <= 1'b0;
      oob_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      fill_q    <= fill_d;
      done_q    <= done_d;
      dv_q      <= dv_d;
      oob_q     <= oob_d;
    end
  end

  wfifo #(
    .W  (AW + DW),
    .FD (FD)
  ) u_wfifo (
    .clk   (pclk),
    .reset (reset),
    .push  (fifo_push),
    .din   ({wr_addr, wr_data}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  vram_sp #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_vram (
    .clk  (pclk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  // Out-of-range reads and idle cycles present zero on the data bus.
  assign disp_dv   = dv_q;
  assign disp_data = (dv_q && !oob_q) ? ram_dout : '0;
  assign clr_busy  = (state_q != ST_IDLE);
  assign clr_done  = done_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter with a transaction-level reference model.
module tb_vram_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2400;
  localparam int FD    = 4;

  // ---------------- clock / reset ----------------
  logic          pclk = 1'b0;
  logic          reset;
  logic          disp_rd;
  logic [AW-1:0] disp_addr;
  logic          disp_dv;
  logic [DW-1:0] disp_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_data;
  logic          clr_busy;
  logic          clr_done;

  always #20 pclk = ~pclk;

  vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .FD(FD)) dut (
    .pclk      (pclk),
    .reset     (reset),
    .disp_rd   (disp_rd),
    .disp_addr (disp_addr),
    .disp_dv   (disp_dv),
    .disp_data (disp_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_start (clr_start),
    .clr_data  (clr_data),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];              // {compare_flag, data} per read issued
  logic [AW+DW-1:0] m_fifo[$];        // pending host writes
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_known [DEPTH];
  bit            m_busy = 1'b0;
  int            m_ptr = -1;          // -1 while waiting for pending writes
  logic [DW-1:0] m_fill = '0;
  bit exp_dv = 1'b0, exp_done = 1'b0, exp_busy = 1'b0, exp_wr_ready = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one RAM slot per cycle, reads first, then oldest pending
  // write, then the next fill cell.
  always @(posedge pclk) begin : model
    int sz0;
    bit busy0;
    logic [AW+DW-1:0] ent;
    int a;
    if (reset) begin
      m_fifo.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_ptr = -1;
      exp_dv = 1'b0;
      exp_done = 1'b0;
      exp_busy = 1'b0;
      exp_wr_ready = 1'b1;
    end else begin
      sz0 = m_fifo.size();
      busy0 = m_busy;
      exp_done = 1'b0;
      exp_dv = disp_rd;
      if (disp_rd) begin
        a = int'(disp_addr);
        if (a >= DEPTH) exp_q.push_back({1'b1, {DW{1'b0}}});
        else            exp_q.push_back({m_known[a], m_mem[a]});
      end else if (sz0 > 0) begin
        ent = m_fifo.pop_front();
        a = int'(ent[AW+DW-1:DW]);
        if (a < DEPTH) begin
          m_mem[a] = ent[DW-1:0];
          m_known[a] = 1'b1;
        end
      end else if (m_busy && m_ptr >= 0) begin
        m_mem[m_ptr] = m_fill;
        m_known[m_ptr] = 1'b1;
        m_ptr++;
        if (m_ptr == DEPTH) begin
          m_busy = 1'b0;
          m_ptr = -1;
          exp_done = 1'b1;
        end
      end
      if (m_busy && m_ptr < 0 && sz0 == 0) m_ptr = 0;
      if (wr_valid && exp_wr_ready) m_fifo.push_back({wr_addr, wr_data});
      if (clr_start && !busy0) begin
        m_busy = 1'b1;
        m_ptr = -1;
        m_fill = clr_data;
      end
      exp_busy = m_busy;
      exp_wr_ready = (m_fifo.size() < FD) && !m_busy;
    end
  end

  // Monitor: compares DUT outputs mid-cycle and retires read expectations.
  always @(negedge pclk) begin : monitor
    logic [DW:0] e;
    if (mon_en) begin
      chk("wr_ready", wr_ready, exp_wr_ready);
      chk("clr_busy", clr_busy, exp_busy);
      chk("clr_done", clr_done, exp_done);
      chk("disp_dv", disp_dv, exp_dv);
      if (disp_dv) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: unexpected valid with data %0h, expected none", disp_data);
        end else begin
          e = exp_q.pop_front();
          if (e[DW]) chk("rd_data", disp_data, e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_rd = 1'b0; disp_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_data = '0;
  endtask

  task automatic rd(input int a);
    disp_rd = 1'b1;
    disp_addr = AW'(a);
    tick();
    disp_rd = 1'b0;
  endtask

  task automatic read_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) rd(i);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n, k, r;
    bit done_seen;
    idle_inputs();
    reset = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_disp_data", disp_data, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_clr_busy", clr_busy, 0);

    // Read after reset: host write to cell 5, then read it back.
    wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 8'h41;
    tick();
    wr_valid = 1'b0;
    tick();
    rd(5);
    chk("rd5_dv", disp_dv, 1);
    chk("rd5_data", disp_data, 8'h41);
    rd(3000);
    chk("rd_oob_data", disp_data, 0);

    // Priority: 20 read cycles while 6 writes are offered; only 4 fit.
    for (int i = 0; i < 20; i++) begin
      disp_rd = 1'b1;
      disp_addr = AW'($urandom_range(0, 63));
      wr_valid = (i < 6);
      wr_addr = AW'(100 + i);
      wr_data = DW'($urandom);
      tick();
      if (i == 3) chk("prio_full_ready", wr_ready, 0);
    end
    idle_inputs();
    repeat (4) tick();
    chk("prio_drained_ready", wr_ready, 1);
    read_range(100, 105);

    // Simultaneous push/pop once the FIFO is full.
    for (int i = 0; i < 12; i++) begin
      disp_rd = (i < 4);
      disp_addr = AW'(5);
      wr_valid = 1'b1;
      wr_addr = AW'(200 + i);
      wr_data = DW'($urandom);
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    read_range(200, 215);

    // Random traffic, including out-of-range addresses.
    for (int i = 0; i < 400; i++) begin
      disp_rd = ($urandom_range(0, 2) == 0);
      disp_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 4095))
                                               : AW'($urandom_range(0, 63));
      wr_valid = $urandom_range(0, 1);
      wr_addr = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 4095))
                                             : AW'($urandom_range(0, 63));
      wr_data = DW'($urandom);
      tick();
    end
    idle_inputs();
    repeat (6) tick();
    read_range(0, 63);

    // Clear with three writes pending to cells the clear will overwrite.
    for (int i = 0; i < 3; i++) begin
      disp_rd = 1'b1;
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 8'h99;
      tick();
    end
    wr_valid = 1'b0;
    clr_start = 1'b1; clr_data = 8'h20;
    tick();
    idle_inputs();
    chk("clr_busy_after_start", clr_busy, 1);
    chk("wr_ready_after_start", wr_ready, 0);
    n = 0;
    while (n < 3000) begin
      tick();
      n++;
      if (clr_done) break;
    end
    chk("clr_len_pending", n, 2404);
    read_range(0, DEPTH - 1);

    // Clear under scan load, with an ignored second clr_start.
    clr_start = 1'b1; clr_data = 8'h33;
    tick();
    clr_start = 1'b0;
    k = 0; r = 0; done_seen = 1'b0;
    while (k < 20000 && !done_seen) begin
      disp_rd = ((k % 800) < 640);
      disp_addr = AW'(k % DEPTH);
      clr_start = (k == 3000);
      clr_data = 8'h77;
      if (k >= 1 && disp_rd) r++;
      tick();
      k++;
      if (clr_done) done_seen = 1'b1;
    end
    idle_inputs();
    chk("scan_done_seen", done_seen, 1);
    chk("scan_clr_len", k, 2401 + r);
    tick();
    chk("scan_busy_after", clr_busy, 0);
    read_range(0, DEPTH - 1);

    // Reset mid-clear while cell 1000 is next to be filled.
    clr_start = 1'b1; clr_data = 8'h55;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (m_ptr != 1000 && n < 3000) begin
      tick();
      n++;
    end
    if (m_ptr != 1000) begin
      checks++;
      errors++;
      $display("FAIL reach_ptr: got %0d expected 1000", m_ptr);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midclr_busy", clr_busy, 0);
    chk("midclr_wr_ready", wr_ready, 1);
    read_range(990, 1010);
    rd(0);
    rd(DEPTH - 1);

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
